// File: rtl/arm_pipe_pkg.sv
// Shared pipeline constants: forwarding-select encoding and default scoreboard sizing.
package arm_pipe_pkg;

  localparam int DEF_REG_CNT    = 16;
  localparam int DEF_PIPE_DEPTH = 3;

  // EXE operand source encoding
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: per-register countdown of pending writes, stall and forward selection.
// Build option: define HAZARD_FORWARDING_EN to enable operand forwarding (only load-use stalls).
module hazard_scoreboard
  import arm_pipe_pkg::*;
#(
  parameter int REG_CNT    = DEF_REG_CNT,
  parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
  parameter int CNT_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [$clog2(REG_CNT)-1:0] id_src1,
  input  logic [$clog2(REG_CNT)-1:0] id_src2,
  input  logic                       id_with_src1,
  input  logic                       id_with_src2,
  input  logic                       id_wb_en,
  input  logic                       id_mem_read,
  input  logic [$clog2(REG_CNT)-1:0] id_dest,
  input  logic                       flush,
  input  logic                       mem_stall,
  output logic                       has_hazard,
  output logic [1:0]                 fwd_src1_sel,
  output logic [1:0]                 fwd_src2_sel
);

  localparam int              IDX_W   = $clog2(REG_CNT);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PIPE_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [REG_CNT-1:0][CNT_W-1:0] count_all;
  logic [REG_CNT-1:0]            load_all;
  logic [CNT_W-1:0]              cnt1, cnt2;
  logic                          ld1, ld2;
  logic                          match1, match2;
  logic                          haz1, haz2;
  logic                          issue;

  assign cnt1   = count_all[id_src1];
  assign cnt2   = count_all[id_src2];
  assign ld1    = load_all[id_src1];
  assign ld2    = load_all[id_src2];
  assign match1 = id_valid & id_with_src1 & (cnt1 != '0);
  assign match2 = id_valid & id_with_src2 & (cnt2 != '0);

  // count==1 means the producer is in WB and its write is visible to ID this cycle.
`ifdef HAZARD_FORWARDING_EN
  assign haz1 = match1 & ld1 & (cnt1 == DEPTH_C);
  assign haz2 = match2 & ld2 & (cnt2 == DEPTH_C);
`else
  assign haz1 = match1 & (cnt1 > ONE_C);
  assign haz2 = match2 & (cnt2 > ONE_C);
`endif

  assign has_hazard = (haz1 | haz2) & ~flush;
  assign issue      = id_valid & ~has_hazard & ~flush & ~mem_stall;

  for (genvar r = 0; r < REG_CNT; r++) begin : g_reg
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ld_q, ld_d;

    // A new issue to this register overrides both the decrement and any older pending write.
    always_comb begin
      cnt_d = cnt_q;
      ld_d  = ld_q;
      if (issue && id_wb_en && (id_dest == IDX_W'(r))) begin
        cnt_d = DEPTH_C;
        ld_d  = id_mem_read;
      end else if (!mem_stall && (cnt_q != '0)) begin
        cnt_d = cnt_q - ONE_C;
        if (cnt_d == '0) ld_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_q <= '0;
        ld_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ld_q  <= ld_d;
      end
    end

    assign count_all[r] = cnt_q;
    assign load_all[r]  = ld_q;
  end

`ifdef HAZARD_FORWARDING_EN
  logic [1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;

  function automatic logic [1:0] sel_for(input logic used, input logic [CNT_W-1:0] cnt);
    if (!used)                        return FWD_RF;
    else if (cnt == DEPTH_C)          return FWD_MEM;
    else if (cnt == DEPTH_C - ONE_C)  return FWD_WB;
    else                              return FWD_RF;
  endfunction

  always_comb begin
    fwd1_d = fwd1_q;
    fwd2_d = fwd2_q;
    if (!mem_stall) begin
      fwd1_d = issue ? sel_for(id_with_src1, cnt1) : FWD_RF;
      fwd2_d = issue ? sel_for(id_with_src2, cnt2) : FWD_RF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fwd1_q <= FWD_RF;
      fwd2_q <= FWD_RF;
    end else begin
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
    end
  end

  assign fwd_src1_sel = fwd1_q;
  assign fwd_src2_sel = fwd2_q;
`else
  // Load flags only steer stalls when forwarding exists.
  logic unused_load;
  assign unused_load  = ^load_all;
  assign fwd_src1_sel = FWD_RF;
  assign fwd_src2_sel = FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations switch with HAZARD_FORWARDING_EN.
module tb_hazard_scoreboard;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_src1, id_src2, id_dest;
  logic       id_with_src1, id_with_src2;
  logic       id_wb_en, id_mem_read;
  logic       flush, mem_stall;
  logic       has_hazard;
  logic [1:0] fwd_src1_sel, fwd_src2_sel;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_with_src1 (id_with_src1),
    .id_with_src2 (id_with_src2),
    .id_wb_en     (id_wb_en),
    .id_mem_read  (id_mem_read),
    .id_dest      (id_dest),
    .flush        (flush),
    .mem_stall    (mem_stall),
    .has_hazard   (has_hazard),
    .fwd_src1_sel (fwd_src1_sel),
    .fwd_src2_sel (fwd_src2_sel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_src1      = '0;
    id_src2      = '0;
    id_with_src1 = 1'b0;
    id_with_src2 = 1'b0;
    id_wb_en     = 1'b0;
    id_mem_read  = 1'b0;
    id_dest      = '0;
    flush        = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (5) tick();
  endtask

  // Issue a producer with no sources; it can never stall.
  task automatic produce(input int dest, input logic is_load);
    idle();
    id_valid    = 1'b1;
    id_wb_en    = 1'b1;
    id_mem_read = is_load;
    id_dest     = 4'(dest);
    tick();
    idle();
  endtask

  // Hold a consumer in ID; scoreboard the hazard sequence, then the selects seen in EXE.
  task automatic consume(input string tag, input int s1, input logic w1, input int s2, input logic w2,
                         input int n_stall, input int e1, input int e2);
    for (int i = 0; i < n_stall; i++) exp_q.push_back(8'd1);
    exp_q.push_back(8'd0);
    idle();
    id_valid     = 1'b1;
    id_src1      = 4'(s1);
    id_with_src1 = w1;
    id_src2      = 4'(s2);
    id_with_src2 = w2;
    #1;
    while (exp_q.size() > 0) begin
      check($sformatf("%s_haz%0d", tag, exp_q.size()), int'(has_hazard), int'(exp_q.pop_front()));
      tick();
    end
    idle();
    #1;
    check({tag, "_sel1"}, int'(fwd_src1_sel), e1);
    check({tag, "_sel2"}, int'(fwd_src2_sel), e2);
  endtask

  initial begin
    idle();
    mem_stall = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    check("rst_haz", int'(has_hazard), 0);
    check("rst_sel1", int'(fwd_src1_sel), 0);
    check("rst_sel2", int'(fwd_src2_sel), 0);
    rst = 1'b1;
    tick();

    // ADD r1 ; SUB r2,r1 back to back
    produce(1, 1'b0);
    consume("add_sub", 1, 1'b1, 0, 1'b0, FWD ? 0 : 2, FWD ? 1 : 0, 0);
    drain();

    // ADD r1 ; bubble ; consumer of r1 on src2
    produce(1, 1'b0);
    tick();
    consume("third", 0, 1'b0, 1, 1'b1, FWD ? 0 : 1, 0, FWD ? 2 : 0);
    drain();

    // LDR r3 ; ADD r4,r3 then a frozen cycle holds the select
    produce(3, 1'b1);
    consume("ldr_use", 3, 1'b1, 0, 1'b0, FWD ? 1 : 2, FWD ? 2 : 0, 0);
    mem_stall = 1'b1;
    tick();
    check("sel_frozen", int'(fwd_src1_sel), FWD ? 2 : 0);
    mem_stall = 1'b0;
    tick();
    check("sel_bubble", int'(fwd_src1_sel), 0);
    drain();

    // mem_stall for 4 cycles with r5 pending at count 3
    produce(5, 1'b1);
    mem_stall    = 1'b1;
    id_valid     = 1'b1;
    id_src1      = 4'd5;
    id_with_src1 = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mstall_haz%0d", i), int'(has_hazard), 1);
      tick();
    end
    mem_stall = 1'b0;
    consume("mstall_rel", 5, 1'b1, 0, 1'b0, FWD ? 1 : 2, FWD ? 2 : 0, 0);
    drain();

    // flush kills a write to r6 whose source r8 is still pending
    produce(8, 1'b1);
    id_valid     = 1'b1;
    id_src1      = 4'd8;
    id_with_src1 = 1'b1;
    id_wb_en     = 1'b1;
    id_dest      = 4'd6;
    flush        = 1'b1;
    #1;
    check("flush_haz", int'(has_hazard), 0);
    tick();
    idle();
    #1;
    check("flush_sel1", int'(fwd_src1_sel), 0);
    check("flush_sel2", int'(fwd_src2_sel), 0);
    consume("flush_r6", 6, 1'b1, 6, 1'b1, 0, 0, 0);
    drain();

    // reset pulse discards the pending write to r7
    produce(7, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    consume("rst_r7", 7, 1'b1, 0, 1'b0, 0, 0, 0);
    drain();

    // WAW: a newer non-load write to r9 replaces the pending load
    produce(9, 1'b1);
    produce(9, 1'b0);
    consume("waw", 9, 1'b1, 0, 1'b0, FWD ? 0 : 2, FWD ? 1 : 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_CNT, default 16, number of architectural registers tracked.
REQ-002 Parameter PIPE_DEPTH, default 3, cycles from issue (ID->EXE) until the producer's WB write is readable by ID; minimum 2.
REQ-003 Parameter CNT_W, default $clog2(PIPE_DEPTH+1), per-register countdown width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 id_valid  input  1  ID holds a real instruction.
REQ-007 id_src1, id_src2  input  $clog2(REG_CNT)  source register indices.
REQ-008 id_with_src1, id_with_src2  input  1  source actually read.
REQ-009 id_wb_en, id_mem_read  input  1  instruction writes a register / is a load.
REQ-010 id_dest  input  $clog2(REG_CNT)  destination register.
REQ-011 flush  input  1  branch taken in EXE; the ID instruction is killed this cycle.
REQ-012 mem_stall  input  1  memory wait; whole pipe frozen.
REQ-013 has_hazard  output  1  freeze IF/ID and insert a bubble into EXE.
REQ-014 fwd_src1_sel, fwd_src2_sel  output  2  EXE operand source, aligned with the instruction in EXE: 0 register file, 1 MEM-stage ALU result, 2 WB value.

Function
REQ-015 Per register: count[r] (CNT_W bits) and load[r] (1 bit); count 0 means no pending write.
REQ-016 issue = id_valid & ~has_hazard & ~flush & ~mem_stall.
REQ-017 On issue with id_wb_en: count[id_dest] <= PIPE_DEPTH and load[id_dest] <= id_mem_read; this overrides the same-cycle decrement and any older pending value (WAW: newest wins).
REQ-018 Each cycle with ~mem_stall, every nonzero count not being set by REQ-017 decrements by 1; load[r] clears when count reaches 0.
REQ-019 mem_stall=1 freezes all counts, load flags and fwd selects.
REQ-020 Source match: id_valid & id_with_srcN & count[id_srcN] != 0.
REQ-021 has_hazard is combinational from current state and ID inputs; it is 0 when flush=1 or id_valid=0.
REQ-022 fwd selects register on issue: count==PIPE_DEPTH gives 1, count==PIPE_DEPTH-1 gives 2, otherwise 0. On a non-issue cycle without mem_stall (bubble or flush), both register 0.
REQ-023 Zero-latency write-through: count==1 (producer in WB) is never a hazard.

Reset
REQ-024 With rst=0 at a clock edge: all count=0, all load=0, fwd_src1_sel=fwd_src2_sel=0. has_hazard=0 on the following cycle.
REQ-025 Reset asserted mid-operation discards all pending entries; no residual stall follows.

Configuration
REQ-026 Macro HAZARD_FORWARDING_EN defined: hazard only on a load-use match with load[src]=1 and count==PIPE_DEPTH; fwd selects follow REQ-022.
REQ-027 Macro undefined: hazard on any match with count>1; fwd selects are tied to 0.

Structure
REQ-028 Shared package arm_pipe_pkg holds the fwd-select encoding constants (FWD_RF=0, FWD_MEM=1, FWD_WB=2) and the default REG_CNT/PIPE_DEPTH.
REQ-029 The design is a single module with no sub-modules; the per-register counter array is a generate loop.

Verification
REQ-030 Reset, then ADD r1 followed by SUB r2,r1 (no forwarding) -> has_hazard=1 for 2 cycles, then SUB issues with fwd sel 0.
REQ-031 HAZARD_FORWARDING_EN, ADD r1 then SUB r2,r1 -> has_hazard=0; SUB in EXE with fwd_src1_sel=1. Third-cycle consumer -> sel=2.
REQ-032 HAZARD_FORWARDING_EN, LDR r3 then ADD r4,r3 -> exactly 1 stall cycle, then issue with fwd_src1_sel=2.
REQ-033 mem_stall held 4 cycles with r5 pending at count=3 -> count stays 3 and has_hazard stays asserted; the decrement resumes after release.
REQ-034 flush concurrent with a valid wb_en instruction to r6 -> count[r6] stays 0; next cycle fwd selects 0, no hazard on r6.
REQ-035 rst=0 pulsed with r7 pending -> next cycle consumer of r7 issues without hazard, selects 0.
